flux_input_conditioner: RTL and testbench
=========================================

// Module: flux_input_conditioner
// PURPOSE
//  Front end between the drive's raw open-collector RDATA/INDEX lines and the flux capture controller.
//  Synchronises both lines, rejects glitches below a minimum width, and enforces a post-pulse holdoff.
//  Emits one toggle per qualified flux pulse on flux_out; the capture controller times successive toggles.
//  Debounces INDEX, and keeps edge, glitch and reject statistics for firmware.
// PARAMETERS
//  SYNC_STAGES  2   synchroniser depth on rdata_n_in/index_n_in (>=2)
//  FILT_W       4   width of cfg_min_width / pulse-width counter
//  HOLDOFF_W    8   width of cfg_holdoff / holdoff counter
//  IDX_DEB_W    16  width of cfg_idx_debounce / index stability counter
// PORTS
//  clk               in   1          system clock (50 MHz)
//  rst_n             in   1          asynchronous active-low reset
//  rdata_n_in        in   1          raw read-data pin, async, active-low pulses
//  index_n_in        in   1          raw index pin, async, active-low
//  cfg_enable        in   1          flux qualification enable
//  cfg_invert        in   1          1: treat rdata as active-high
//  cfg_min_width     in   FILT_W     minimum active cycles to accept (0 treated as 1)
//  cfg_holdoff       in   HOLDOFF_W  dead cycles after acceptance
//  cfg_idx_debounce  in   IDX_DEB_W  stable cycles before index_out changes (0 treated as 1)
//  stat_clear        in   1          synchronous clear of the three statistics counters
//  flux_out          out  1          toggles once per accepted pulse (feeds capture flux_in)
//  flux_pulse        out  1          1-cycle strobe, same cycle flux_out toggles
//  index_out         out  1          debounced index, active-high
//  index_pulse       out  1          1-cycle strobe on index_out rising
//  flux_edges        out  32         accepted pulse count, wraps
//  glitch_cnt        out  16         pulses shorter than min width, saturates at 16'hFFFF
//  reject_cnt        out  16         new pulses starting inside holdoff, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset
//   - Synchroniser flops: 1 (pins idle high).
//   - FSM: ARM.
//   - All outputs and counters: 0.
//  act = cfg_invert ? sync_rdata : ~sync_rdata; act_prev is act registered.
//  FSM (cfg_enable=0 forces ARM from any state; counters and flux_out hold)
//   - ARM: go to IDLE when enable=1 and act=0. A line already active at enable is never counted.
//   - IDLE, act=1: w=1. If max(min,1)=1, ACCEPT; else go to MEASURE.
//   - MEASURE, act=1: w++. When w reaches max(min,1), ACCEPT.
//   - MEASURE, act=0: glitch_cnt++ (saturating), go to IDLE.
//   - ACCEPT (registered at that edge):
//       flux_pulse=1, flux_out toggles, flux_edges++,
//       holdoff counter loaded with cfg_holdoff, go to HOLDOFF.
//   - HOLDOFF: decrement each cycle. Each act rising edge (act & ~act_prev) here increments reject_cnt.
//     When the counter is 0 and act=0, go to IDLE. When the counter is 0 and act=1, stay until act=0,
//     so a long pulse counts once.
//  Latency: pin asserted first sampled at edge k -> flux_pulse high after edge k+SYNC_STAGES+max(min,1)-1.
//  Config
//   - Sampled live, except cfg_holdoff, which is latched at ACCEPT; a mid-holdoff change affects only the next pulse.
//   - cfg_enable dropping during MEASURE aborts without counting a glitch.
//  Index
//   - Independent of cfg_enable.
//   - index_out takes the new synchronised level after it has been stable for max(deb,1) consecutive cycles.
//   - index_pulse is asserted in the cycle index_out rises.
//  Counters
//   - stat_clear wins over a coincident increment (result 0).
//   - flux_edges wraps 32'hFFFFFFFF -> 0.
// STRUCTURE
//  Package flux_cond_pkg:
//   - FSM state encoding (ARM, IDLE, MEASURE, HOLDOFF).
//   - Statistics widths.
//   - Saturating-increment function.
//  Sub-module sync_ff: SYNC_STAGES-deep, reset-to-1 synchroniser, instantiated twice (rdata, index).
//  All remaining logic is flat in this module.
// TESTING
//  1. min=3, holdoff=10, 4-cycle low pulse -> one flux_pulse after edge k+4, flux_out 0->1, flux_edges=1.
//  2. min=3, 2-cycle low pulse -> no flux_pulse, glitch_cnt=1, flux_out unchanged.
//  3. Pulse accepted, second pulse starts 5 cycles later (holdoff=10) -> reject_cnt=1, flux_edges=1.
//  4. rdata held low while cfg_enable 0->1 -> nothing until release; next 4-cycle pulse -> flux_edges=1.
//  5. deb=8, index low 5 cycles then high, later low 20 cycles -> one index_pulse, 8 cycles after stable low.
//  6. glitch_cnt preset to 16'hFFFF, extra glitch -> stays 16'hFFFF. stat_clear coincident with accept -> flux_edges=0.
//     rst_n mid-HOLDOFF -> all outputs 0, FSM ARM.

Source files
------------

// File: rtl/flux_cond_pkg.sv
// Shared types and helpers for the flux input conditioner.
package flux_cond_pkg;

   // Qualification FSM states; exported on dbg_state for checkers.
   typedef enum logic [1:0] {
      ST_ARM     = 2'd0,
      ST_IDLE    = 2'd1,
      ST_MEASURE = 2'd2,
      ST_HOLDOFF = 2'd3
   } flux_state_t;

   localparam int EDGE_CNT_W = 32;
   localparam int STAT_CNT_W = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [STAT_CNT_W-1:0] sat_inc(input logic [STAT_CNT_W-1:0] v);
      return (v == {STAT_CNT_W{1'b1}}) ? v : v + STAT_CNT_W'(1);
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for an async, idle-high pin. Resets to 1 so an
// idle line never looks like a pulse coming out of reset.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the raw pin through the flop chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '1;
      else        sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/flux_input_conditioner.sv
// Flux/index front end: synchronises RDATA and INDEX, qualifies flux pulses
// by minimum width with a post-accept holdoff, toggles flux_out per accepted
// pulse, debounces INDEX and keeps statistics counters.
module flux_input_conditioner
   import flux_cond_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_W      = 4,
   parameter int HOLDOFF_W   = 8,
   parameter int IDX_DEB_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rdata_n_in,
   input  logic                  index_n_in,
   input  logic                  cfg_enable,
   input  logic                  cfg_invert,
   input  logic [FILT_W-1:0]     cfg_min_width,
   input  logic [HOLDOFF_W-1:0]  cfg_holdoff,
   input  logic [IDX_DEB_W-1:0]  cfg_idx_debounce,
   input  logic                  stat_clear,
   output logic                  flux_out,
   output logic                  flux_pulse,
   output logic                  index_out,
   output logic                  index_pulse,
   output logic [EDGE_CNT_W-1:0] flux_edges,
   output logic [STAT_CNT_W-1:0] glitch_cnt,
   output logic [STAT_CNT_W-1:0] reject_cnt,
   output flux_state_t           dbg_state
);

   logic sync_rdata;
   logic sync_index;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_rdata (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (rdata_n_in),
      .q_o   (sync_rdata)
   );

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_index (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (index_n_in),
      .q_o   (sync_index)
   );

   // ---------------- flux qualification ----------------
   flux_state_t           state_q;
   logic                  act;
   logic                  act_prev_q;
   logic [FILT_W-1:0]     w_q;
   logic [HOLDOFF_W-1:0]  hold_q;
   logic                  flux_out_q;
   logic                  flux_pulse_q;
   logic [EDGE_CNT_W-1:0] flux_edges_q;
   logic [STAT_CNT_W-1:0] glitch_q;
   logic [STAT_CNT_W-1:0] reject_q;

   logic [FILT_W:0]       min_eff;
   logic [FILT_W:0]       w_inc;
   logic                  accept_now;

   assign act     = cfg_invert ? sync_rdata : ~sync_rdata;
   assign min_eff = (cfg_min_width == '0) ? (FILT_W+1)'(1) : {1'b0, cfg_min_width};
   assign w_inc   = {1'b0, w_q} + (FILT_W+1)'(1);

   // A pulse qualifies on the cycle its active width reaches the minimum.
   always_comb begin
      accept_now = 1'b0;
      if (cfg_enable && act) begin
         if (state_q == ST_IDLE)    accept_now = (min_eff == (FILT_W+1)'(1));
         if (state_q == ST_MEASURE) accept_now = (w_inc >= min_eff);
      end
   end

   // Qualification FSM plus the flux statistics it drives; clear beats increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_ARM;
         act_prev_q   <= 1'b0;
         w_q          <= '0;
         hold_q       <= '0;
         flux_out_q   <= 1'b0;
         flux_pulse_q <= 1'b0;
         flux_edges_q <= '0;
         glitch_q     <= '0;
         reject_q     <= '0;
      end else begin
         flux_pulse_q <= 1'b0;
         act_prev_q   <= act;
         if (!cfg_enable) begin
            state_q <= ST_ARM;
         end else if (accept_now) begin
            flux_pulse_q <= 1'b1;
            flux_out_q   <= ~flux_out_q;
            flux_edges_q <= flux_edges_q + EDGE_CNT_W'(1);
            hold_q       <= cfg_holdoff;
            state_q      <= ST_HOLDOFF;
         end else begin
            case (state_q)
               ST_ARM: begin
                  // Wait for an inactive line so a pulse in progress is never counted.
                  if (!act) state_q <= ST_IDLE;
               end
               ST_IDLE: begin
                  if (act) begin
                     w_q     <= FILT_W'(1);
                     state_q <= ST_MEASURE;
                  end
               end
               ST_MEASURE: begin
                  if (act) begin
                     w_q <= w_inc[FILT_W-1:0];
                  end else begin
                     glitch_q <= sat_inc(glitch_q);
                     state_q  <= ST_IDLE;
                  end
               end
               ST_HOLDOFF: begin
                  if (hold_q != '0) hold_q <= hold_q - HOLDOFF_W'(1);
                  if (act && !act_prev_q) reject_q <= sat_inc(reject_q);
                  // A long pulse keeps us here until it releases, so it counts once.
                  if (hold_q == '0 && !act) state_q <= ST_IDLE;
               end
               default: state_q <= ST_ARM;
            endcase
         end
         if (stat_clear) begin
            flux_edges_q <= '0;
            glitch_q     <= '0;
            reject_q     <= '0;
         end
      end
   end

   // ---------------- index debounce ----------------
   logic                 idx_lvl;
   logic                 index_out_q;
   logic                 index_pulse_q;
   logic [IDX_DEB_W-1:0] idx_cnt_q;
   logic [IDX_DEB_W:0]   deb_eff;
   logic [IDX_DEB_W:0]   idx_inc;

   assign idx_lvl = ~sync_index;
   assign deb_eff = (cfg_idx_debounce == '0) ? (IDX_DEB_W+1)'(1) : {1'b0, cfg_idx_debounce};
   assign idx_inc = {1'b0, idx_cnt_q} + (IDX_DEB_W+1)'(1);

   // Adopt a new index level only after it has held for the debounce time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         index_out_q   <= 1'b0;
         index_pulse_q <= 1'b0;
         idx_cnt_q     <= '0;
      end else begin
         index_pulse_q <= 1'b0;
         if (idx_lvl == index_out_q) begin
            idx_cnt_q <= '0;
         end else if (idx_inc >= deb_eff) begin
            index_out_q   <= idx_lvl;
            index_pulse_q <= idx_lvl;
            idx_cnt_q     <= '0;
         end else begin
            idx_cnt_q <= idx_inc[IDX_DEB_W-1:0];
         end
      end
   end

   assign flux_out    = flux_out_q;
   assign flux_pulse  = flux_pulse_q;
   assign flux_edges  = flux_edges_q;
   assign glitch_cnt  = glitch_q;
   assign reject_cnt  = reject_q;
   assign index_out   = index_out_q;
   assign index_pulse = index_pulse_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_flux_input_conditioner.sv
// Bench for flux_input_conditioner: directed pulses with expected accepts
// queued at drive time and matched when flux_pulse / index_pulse fire.
module tb_flux_input_conditioner;
   import flux_cond_pkg::*;

   localparam int SYNC_STAGES = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rdata_n_in;
   logic        index_n_in;
   logic        cfg_enable;
   logic        cfg_invert;
   logic [3:0]  cfg_min_width;
   logic [7:0]  cfg_holdoff;
   logic [15:0] cfg_idx_debounce;
   logic        stat_clear;
   logic        flux_out;
   logic        flux_pulse;
   logic        index_out;
   logic        index_pulse;
   logic [31:0] flux_edges;
   logic [15:0] glitch_cnt;
   logic [15:0] reject_cnt;
   flux_state_t dbg_state;

   flux_input_conditioner #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .rdata_n_in       (rdata_n_in),
      .index_n_in       (index_n_in),
      .cfg_enable       (cfg_enable),
      .cfg_invert       (cfg_invert),
      .cfg_min_width    (cfg_min_width),
      .cfg_holdoff      (cfg_holdoff),
      .cfg_idx_debounce (cfg_idx_debounce),
      .stat_clear       (stat_clear),
      .flux_out         (flux_out),
      .flux_pulse       (flux_pulse),
      .index_out        (index_out),
      .index_pulse      (index_pulse),
      .flux_edges       (flux_edges),
      .glitch_cnt       (glitch_cnt),
      .reject_cnt       (reject_cnt),
      .dbg_state        (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_cyc_q[$];
   logic [31:0] idx_cyc_q[$];
   logic [31:0] exp_edges = 0;
   logic        mdl_flux_out = 1'b0;
   logic [31:0] mon_e;
   logic [31:0] mon_c;
   logic [31:0] mon_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Match every flux strobe against the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && flux_pulse) begin
         if (exp_q.size() == 0) begin
            check("unexpected_flux_pulse", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            mon_c = exp_cyc_q.pop_front();
            mdl_flux_out = ~mdl_flux_out;
            check("flux_edges_at_pulse", flux_edges, mon_e);
            check("flux_pulse_cycle", cyc, mon_c);
            check("flux_out_at_pulse", flux_out, mdl_flux_out);
         end
      end
   end

   // Match every index strobe against its expected cycle.
   always @(negedge clk) begin
      if (rst_n && index_pulse) begin
         if (idx_cyc_q.size() == 0) begin
            check("unexpected_index_pulse", 1, 0);
         end else begin
            mon_i = idx_cyc_q.pop_front();
            check("index_pulse_cycle", cyc, mon_i);
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; drives a low pulse of len cycles on rdata.
   task automatic drive_pulse(input int len, input bit accept);
      int c0;
      int m;
      c0 = cyc;
      m  = (cfg_min_width == 0) ? 1 : int'(cfg_min_width);
      rdata_n_in = 1'b0;
      if (accept) begin
         exp_edges = exp_edges + 1;
         exp_q.push_back(exp_edges);
         exp_cyc_q.push_back(32'(c0 + SYNC_STAGES + m));
      end
      repeat (len) @(negedge clk);
      rdata_n_in = 1'b1;
   endtask

   task automatic drive_index(input int len, input bit expect_rise);
      int c0;
      int d;
      c0 = cyc;
      d  = (cfg_idx_debounce == 0) ? 1 : int'(cfg_idx_debounce);
      index_n_in = 1'b0;
      if (expect_rise) idx_cyc_q.push_back(32'(c0 + SYNC_STAGES + d));
      repeat (len) @(negedge clk);
      index_n_in = 1'b1;
   endtask

   task automatic clear_stats();
      stat_clear = 1'b1;
      @(negedge clk);
      stat_clear = 1'b0;
      exp_edges  = 0;
   endtask

   task automatic check_drained(input string tag);
      check(tag, exp_q.size(), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; rdata_n_in = 1'b1; index_n_in = 1'b1;
      cfg_enable = 1'b0; cfg_invert = 1'b0; cfg_min_width = 4'd3;
      cfg_holdoff = 8'd10; cfg_idx_debounce = 16'd8; stat_clear = 1'b0;
      settle(3);
      check("rst_flux_out", flux_out, 0);
      check("rst_flux_pulse", flux_pulse, 0);
      check("rst_index_out", index_out, 0);
      check("rst_counters", {flux_edges, glitch_cnt, reject_cnt}, 0);
      check("rst_state", dbg_state, ST_ARM);

      rst_n = 1'b1; cfg_enable = 1'b1;
      settle(5);
      check("arm_to_idle", dbg_state, ST_IDLE);

      // 1: accepted 4-cycle pulse
      drive_pulse(4, 1'b1);
      settle(30);
      check("t1_flux_out", flux_out, 1);
      check("t1_edges", flux_edges, 1);
      check_drained("t1_pending");

      // 2: 2-cycle glitch
      drive_pulse(2, 1'b0);
      settle(20);
      check("t2_glitch", glitch_cnt, 1);
      check("t2_flux_out", flux_out, 1);
      check("t2_edges", flux_edges, 1);

      clear_stats();
      check("clear_counters", {flux_edges, glitch_cnt, reject_cnt}, 0);

      // 3: second pulse inside holdoff
      drive_pulse(4, 1'b1);
      settle(1);
      drive_pulse(4, 1'b0);
      settle(30);
      check("t3_reject", reject_cnt, 1);
      check("t3_edges", flux_edges, 1);
      check_drained("t3_pending");

      // 4: line active while enabling
      clear_stats();
      cfg_enable = 1'b0;
      settle(2);
      rdata_n_in = 1'b0;
      settle(5);
      cfg_enable = 1'b1;
      settle(10);
      check("t4_held_arm", dbg_state, ST_ARM);
      rdata_n_in = 1'b1;
      settle(10);
      check("t4_released_idle", dbg_state, ST_IDLE);
      drive_pulse(4, 1'b1);
      settle(30);
      check("t4_edges", flux_edges, 1);
      check("t4_glitch", glitch_cnt, 0);

      // enable drop during MEASURE aborts without a glitch
      cfg_min_width = 4'd8;
      rdata_n_in = 1'b0;
      settle(4);
      check("abort_in_measure", dbg_state, ST_MEASURE);
      cfg_enable = 1'b0;
      settle(8);
      rdata_n_in = 1'b1;
      settle(5);
      cfg_enable = 1'b1;
      settle(5);
      check("abort_glitch", glitch_cnt, 0);
      check("abort_edges", flux_edges, 1);

      // min width 0 behaves as 1
      cfg_min_width = 4'd0;
      drive_pulse(1, 1'b1);
      settle(30);
      check("min0_edges", flux_edges, 2);
      cfg_min_width = 4'd3;

      // 5: index debounce
      drive_index(5, 1'b0);
      settle(20);
      check("t5_short_index", index_out, 0);
      drive_index(20, 1'b1);
      check("t5_index_high", index_out, 1);
      settle(20);
      check("t5_index_low", index_out, 0);
      check("t5_idx_pending", idx_cyc_q.size(), 0);

      // 6: glitch counter saturation
      force dut.glitch_q = 16'hFFFF;
      @(negedge clk);
      release dut.glitch_q;
      settle(1);
      check("t6_preset", glitch_cnt, 16'hFFFF);
      drive_pulse(2, 1'b0);
      settle(20);
      check("t6_glitch_sat", glitch_cnt, 16'hFFFF);

      // flux_edges wrap
      force dut.flux_edges_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.flux_edges_q;
      exp_edges = 32'hFFFF_FFFF;
      settle(1);
      drive_pulse(4, 1'b1);
      settle(30);
      check("wrap_edges", flux_edges, 0);

      // stat_clear coincident with accept (accept edge is c0+5)
      rdata_n_in = 1'b0;
      exp_q.push_back(32'd0);
      exp_cyc_q.push_back(32'(cyc + SYNC_STAGES + 3));
      settle(4);
      rdata_n_in = 1'b1;
      stat_clear = 1'b1;
      @(negedge clk);
      stat_clear = 1'b0;
      exp_edges = 0;
      settle(30);
      check("clr_accept_edges", flux_edges, 0);
      check("clr_accept_glitch", glitch_cnt, 0);
      check_drained("clr_pending");

      // reset in the middle of HOLDOFF
      drive_pulse(4, 1'b1);
      settle(2);
      check("pre_rst_holdoff", dbg_state, ST_HOLDOFF);
      rst_n = 1'b0;
      #1;
      check("midrst_state", dbg_state, ST_ARM);
      check("midrst_outputs", {flux_out, flux_pulse, index_out, index_pulse}, 0);
      check("midrst_counters", {flux_edges, glitch_cnt, reject_cnt}, 0);
      mdl_flux_out = 1'b0;
      exp_edges = 0;
      settle(2);
      rst_n = 1'b1;
      settle(5);
      check("post_rst_idle", dbg_state, ST_IDLE);
      check_drained("final_pending");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Hard stop if the stimulus ever stalls.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
